load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access stage of the RV64I pipeline. Executes LOAD/STORE ops from execute (ALU_OP_ADD effective address).
//  Runs one transaction at a time on a 64-bit doubleword memory port.
//  Generates byte strobes and lane-shifted store data; sign/zero-extends load data per LOAD_FUNC3.
//  Result goes to writeback (SEL_LOAD_DATA); misaligned/illegal/bus-timeout faults are reported.
// PARAMETERS
//  TIMEOUT_CYCLES  16  WAIT cycles without response/accept before bus error; 1..255
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   synchronous reset, active-high
//  req_valid       in   1   execute offers an access
//  req_ready       out  1   unit can accept (high only in IDLE)
//  req_is_store    in   1   1 = STORE (STORE_FUNC3), 0 = LOAD (LOAD_FUNC3)
//  req_func3       in   3   width/sign code
//  req_addr        in   64  effective byte address (dw)
//  req_wdata       in   64  rs2 value, low bytes significant
//  req_rd          in   5   destination register for loads
//  mem_req_valid   out  1   memory request
//  mem_req_ready   in   1   memory accepts request
//  mem_we          out  1   1 = write
//  mem_addr        out  64  {req_addr[63:3], 3'b000}
//  mem_wdata       out  64  lane-aligned store data
//  mem_wstrb       out  8   byte enables (0 for reads)
//  mem_rsp_valid   in   1   read data valid (reads only)
//  mem_rdata       in   64  read doubleword
//  done_valid      out  1   one-cycle completion pulse to writeback
//  done_rd         out  5   captured rd (0 for stores)
//  done_data       out  64  extended load data (0 for stores/faults)
//  exc_misaligned  out  1   valid with done_valid
//  exc_illegal     out  1   valid with done_valid; undefined func3
//  exc_bus_err     out  1   valid with done_valid; timeout
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0. All outputs 0 except req_ready = 1. rst mid-transaction aborts it.
//  FSM IDLE -> REQ -> (load) WAIT -> DONE -> IDLE. Store: REQ -> DONE on accept.
//  IDLE: req_valid & req_ready captures all req_* fields.
//   - Illegal: load func3 = 3'b111, or store func3[2] = 1 -> DONE, exc_illegal = 1.
//   - Else misaligned: size = 1<<func3[1:0]; (addr & (size-1)) != 0 -> DONE, exc_misaligned = 1.
//   - Faulting requests issue no memory request. Legal requests -> REQ.
//  REQ: mem_req_valid = 1; outputs held stable until mem_req_ready (AXI-style, no drop).
//   - Accepted store -> DONE. Accepted load -> WAIT.
//   - Counter increments each non-accepted cycle; reaching TIMEOUT_CYCLES -> DONE, exc_bus_err = 1.
//  WAIT: counter cleared on entry. mem_rsp_valid captures mem_rdata -> DONE.
//   - Counter runs; timeout -> DONE, exc_bus_err = 1.
//   - mem_rsp_valid outside WAIT is ignored; response comes >= 1 cycle after accept.
//  DONE: done_valid = 1 for exactly one cycle -> IDLE. No back-pressure from writeback.
//  Store lanes: off = addr[2:0].
//   - SB: wstrb = 8'h01<<off; SH: 8'h03<<off; SW: 8'h0F<<off; SD: 8'hFF.
//   - wdata = req_wdata << (8*off); bytes outside the strobe are don't-care.
//  Load extract: field = mem_rdata >> (8*off).
//   - LB/LH/LW sign-extend 8/16/32 bits to 64; LBU/LHU/LWU zero-extend; LD passes through.
//  Latency (zero wait states, accept at cycle T): store done_valid at T+2; load rsp at T+2, done_valid at T+3.
//  Fault path: done_valid at T+1. Exactly one exc_* may be set. done_data = 0 when any exc_* is set.
// TESTING
//  LB addr 0x1003, rdata byte3 = 0x80 -> mem_addr 0x1000, done_data 0xFFFF_FFFF_FFFF_FF80, done at T+3.
//  LBU same -> done_data 0x80. LWU addr 0x1004, rdata[63:32] = 0x8000_0001 -> 0x0000_0000_8000_0001.
//  SH addr 0x2006, wdata 0xABCD -> mem_wstrb 8'hC0, mem_wdata[63:48] = 0xABCD, mem_we = 1, done at T+2.
//  LW addr 0x1002 -> no mem_req_valid, exc_misaligned at T+1. Store func3 3'b100 -> exc_illegal.
//  mem_req_ready low 3 cycles -> fields stable, done 3 cycles late. Load with no rsp -> exc_bus_err after 16 cycles.
//  rst asserted in WAIT -> next cycle IDLE, req_ready = 1, no done_valid; a late mem_rsp_valid is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// RV64I memory-access stage: one LOAD/STORE at a time on a 64-bit doubleword port,
// with lane steering, load extension and misaligned/illegal/bus-timeout faults.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_func3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        done_valid,
  output logic [4:0]  done_rd,
  output logic [63:0] done_data,
  output logic        exc_misaligned,
  output logic        exc_illegal,
  output logic        exc_bus_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_is_store;
  logic [2:0]  r_func3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [4:0]  r_rd;
  logic [63:0] r_data;
  logic        r_exc_mis, r_exc_ill, r_exc_bus;

  logic        w_accept, w_illegal, w_misaligned, w_timeout;
  logic [2:0]  w_size_mask;
  logic [7:0]  w_wstrb;
  logic [63:0] w_load_data;
  logic        w_in_req, w_in_done, w_store_req;

  function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                              input logic [2:0]  off,
                                              input logic [2:0]  f3);
    logic [63:0] field;
    field = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{56{field[7]}}, field[7:0]};
      3'b001:  load_extend = {{48{field[15]}}, field[15:0]};
      3'b010:  load_extend = {{32{field[31]}}, field[31:0]};
      3'b100:  load_extend = {56'd0, field[7:0]};
      3'b101:  load_extend = {48'd0, field[15:0]};
      3'b110:  load_extend = {32'd0, field[31:0]};
      default: load_extend = field;
    endcase
  endfunction

  assign w_accept    = req_valid & (r_state == S_IDLE);
  assign w_illegal   = req_is_store ? req_func3[2] : (req_func3 == 3'b111);
  assign w_timeout   = (r_cnt == TO_LAST);
  assign w_load_data = load_extend(mem_rdata, r_addr[2:0], r_func3);

  always_comb begin
    w_size_mask = 3'b111;
    case (req_func3[1:0])
      2'b00:   w_size_mask = 3'b000;
      2'b01:   w_size_mask = 3'b001;
      2'b10:   w_size_mask = 3'b011;
      default: w_size_mask = 3'b111;
    endcase
  end

  assign w_misaligned = (req_addr[2:0] & w_size_mask) != 3'b000;

  always_comb begin
    w_wstrb = 8'hFF;
    case (r_func3[1:0])
      2'b00:   w_wstrb = 8'h01 << r_addr[2:0];
      2'b01:   w_wstrb = 8'h03 << r_addr[2:0];
      2'b10:   w_wstrb = 8'h0F << r_addr[2:0];
      default: w_wstrb = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // The counter only advances on stalled REQ/WAIT cycles and is zeroed on every state entry.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = 8'd0;
        if (req_valid) begin
          w_state_next = (w_illegal || w_misaligned) ? S_DONE : S_REQ;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_next = r_is_store ? S_DONE : S_WAIT;
          w_cnt_next   = 8'd0;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid || w_timeout) begin
          w_state_next = S_DONE;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 8'd0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_func3    <= 3'd0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_rd       <= 5'd0;
      r_data     <= 64'd0;
      r_exc_mis  <= 1'b0;
      r_exc_ill  <= 1'b0;
      r_exc_bus  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_store <= req_is_store;
            r_func3    <= req_func3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_is_store ? 5'd0 : req_rd;
            r_data     <= 64'd0;
            r_exc_ill  <= w_illegal;
            r_exc_mis  <= ~w_illegal & w_misaligned;
            r_exc_bus  <= 1'b0;
          end
        end
        S_REQ: begin
          if (!mem_req_ready && w_timeout) r_exc_bus <= 1'b1;
        end
        S_WAIT: begin
          if (mem_rsp_valid) r_data <= w_load_data;
          else if (w_timeout) r_exc_bus <= 1'b1;
        end
        default: begin
          r_exc_bus <= r_exc_bus;
        end
      endcase
    end
  end

  assign w_in_req    = (r_state == S_REQ);
  assign w_in_done   = (r_state == S_DONE);
  assign w_store_req = w_in_req & r_is_store;

  assign req_ready      = (r_state == S_IDLE);
  assign mem_req_valid  = w_in_req;
  assign mem_we         = w_store_req;
  assign mem_addr       = w_in_req ? {r_addr[63:3], 3'b000} : 64'd0;
  assign mem_wdata      = w_store_req ? (r_wdata << {r_addr[2:0], 3'b000}) : 64'd0;
  assign mem_wstrb      = w_store_req ? w_wstrb : 8'h00;
  assign done_valid     = w_in_done;
  assign done_rd        = w_in_done ? r_rd : 5'd0;
  assign done_data      = w_in_done ? r_data : 64'd0;
  assign exc_misaligned = w_in_done & r_exc_mis;
  assign exc_illegal    = w_in_done & r_exc_ill;
  assign exc_bus_err    = w_in_done & r_exc_bus;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a completion scoreboard and
// hand-written sequences for back-pressure, timeout and mid-transaction reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_func3;
  logic [63:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic [63:0] done_data;
  logic        exc_misaligned, exc_illegal, exc_bus_err;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .exc_misaligned(exc_misaligned), .exc_illegal(exc_illegal), .exc_bus_err(exc_bus_err)
  );

  always #5 clk = ~clk;

  // exc is {illegal, misaligned, bus_err}; lat counts cycles from the accept edge.
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          stall;
    logic        rsp;
    logic [63:0] e_maddr;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    logic [2:0]  e_exc;
    int          e_lat;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [2:0]  exc;
    int          lat;
  } exp_t;

  vec_t vt[20];
  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t        e;
    exp_t        g;
    bit          done;
    int          nreq;
    bit          rsp_pend;
    logic [63:0] mask;
    for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{v.e_strb[b]}};
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), req_ready, 1'b1);
    req_valid    = 1'b1;
    req_is_store = v.st;
    req_func3    = v.f3;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_rd       = v.rd;
    e.rd = v.e_rd; e.data = v.e_data; e.exc = v.e_exc; e.lat = v.e_lat;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    done = 1'b0; nreq = 0; rsp_pend = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (rsp_pend) begin
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
        rsp_pend      = 1'b0;
      end
      mem_req_ready = (k > v.stall);
      if (mem_req_valid) begin
        nreq++;
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_maddr);
        chk($sformatf("v%0d mem_we", idx), mem_we, v.st);
        chk($sformatf("v%0d mem_wstrb", idx), mem_wstrb, v.e_strb);
        if (v.st) chk($sformatf("v%0d mem_wdata", idx), mem_wdata & mask, v.e_wdata & mask);
        if (mem_req_ready && !v.st && v.rsp) rsp_pend = 1'b1;
      end
      if (done_valid) begin
        done = 1'b1;
        chk($sformatf("v%0d sb_nonempty", idx), sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
          g = sbq.pop_front();
          chk($sformatf("v%0d done_rd", idx), done_rd, g.rd);
          chk($sformatf("v%0d done_data", idx), done_data, g.data);
          chk($sformatf("v%0d exc", idx), {exc_illegal, exc_misaligned, exc_bus_err}, g.exc);
          chk($sformatf("v%0d latency", idx), k, g.lat);
          chk($sformatf("v%0d exc_onehot", idx),
              $countones({exc_illegal, exc_misaligned, exc_bus_err}) <= 1, 1'b1);
        end
      end
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    chk($sformatf("v%0d done_seen", idx), done, 1'b1);
    chk($sformatf("v%0d mem_req_issued", idx), nreq != 0, !(v.e_exc[2] || v.e_exc[1]));
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", idx), done_valid, 1'b0);
  endtask

  initial begin
    vt[0]  = '{1'b0, 3'd0, 64'h1003, 64'h0, 5'd5, 64'h11223344_80667788, 0, 1'b1,
               64'h1000, 8'h00, 64'h0, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, 3'b000, 3};
    vt[1]  = '{1'b0, 3'd4, 64'h1003, 64'h0, 5'd6, 64'h11223344_80667788, 0, 1'b1,
               64'h1000, 8'h00, 64'h0, 5'd6, 64'h80, 3'b000, 3};
    vt[2]  = '{1'b0, 3'd6, 64'h1004, 64'h0, 5'd7, 64'h80000001_DEADBEEF, 0, 1'b1,
               64'h1000, 8'h00, 64'h0, 5'd7, 64'h0000_0000_8000_0001, 3'b000, 3};
    vt[3]  = '{1'b0, 3'd2, 64'h1004, 64'h0, 5'd8, 64'h80000001_DEADBEEF, 0, 1'b1,
               64'h1000, 8'h00, 64'h0, 5'd8, 64'hFFFF_FFFF_8000_0001, 3'b000, 3};
    vt[4]  = '{1'b0, 3'd1, 64'h1006, 64'h0, 5'd9, 64'h80000001_DEADBEEF, 0, 1'b1,
               64'h1000, 8'h00, 64'h0, 5'd9, 64'hFFFF_FFFF_FFFF_8000, 3'b000, 3};
    vt[5]  = '{1'b0, 3'd5, 64'h1002, 64'h0, 5'd10, 64'h80000001_DEADBEEF, 0, 1'b1,
               64'h1000, 8'h00, 64'h0, 5'd10, 64'h0000_0000_0000_DEAD, 3'b000, 3};
    vt[6]  = '{1'b0, 3'd3, 64'h1008, 64'h0, 5'd11, 64'h01234567_89ABCDEF, 0, 1'b1,
               64'h1008, 8'h00, 64'h0, 5'd11, 64'h01234567_89ABCDEF, 3'b000, 3};
    vt[7]  = '{1'b1, 3'd1, 64'h2006, 64'hFFFF_FFFF_FFFF_ABCD, 5'd12, 64'h0, 0, 1'b0,
               64'h2000, 8'hC0, 64'hABCD_0000_0000_0000, 5'd0, 64'h0, 3'b000, 2};
    vt[8]  = '{1'b1, 3'd0, 64'h2001, 64'h1234_5678_9ABC_DE5A, 5'd1, 64'h0, 0, 1'b0,
               64'h2000, 8'h02, 64'h0000_0000_0000_5A00, 5'd0, 64'h0, 3'b000, 2};
    vt[9]  = '{1'b1, 3'd2, 64'h2004, 64'hAAAA_AAAA_1122_3344, 5'd2, 64'h0, 0, 1'b0,
               64'h2000, 8'hF0, 64'h1122_3344_0000_0000, 5'd0, 64'h0, 3'b000, 2};
    vt[10] = '{1'b1, 3'd3, 64'h2008, 64'h0102_0304_0506_0708, 5'd3, 64'h0, 0, 1'b0,
               64'h2008, 8'hFF, 64'h0102_0304_0506_0708, 5'd0, 64'h0, 3'b000, 2};
    vt[11] = '{1'b0, 3'd2, 64'h1002, 64'h0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1,
               64'h0, 8'h00, 64'h0, 5'd13, 64'h0, 3'b010, 1};
    vt[12] = '{1'b1, 3'd1, 64'h2003, 64'h1234, 5'd4, 64'h0, 0, 1'b0,
               64'h0, 8'h00, 64'h0, 5'd0, 64'h0, 3'b010, 1};
    vt[13] = '{1'b1, 3'd4, 64'h2000, 64'h1234, 5'd4, 64'h0, 0, 1'b0,
               64'h0, 8'h00, 64'h0, 5'd0, 64'h0, 3'b100, 1};
    vt[14] = '{1'b0, 3'd7, 64'h1000, 64'h0, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1,
               64'h0, 8'h00, 64'h0, 5'd14, 64'h0, 3'b100, 1};
    vt[15] = '{1'b1, 3'd2, 64'h2000, 64'h0000_0000_CAFE_F00D, 5'd4, 64'h0, 3, 1'b0,
               64'h2000, 8'h0F, 64'h0000_0000_CAFE_F00D, 5'd0, 64'h0, 3'b000, 5};
    vt[16] = '{1'b0, 3'd3, 64'h1010, 64'h0, 5'd15, 64'hFEDC_BA98_7654_3210, 3, 1'b1,
               64'h1010, 8'h00, 64'h0, 5'd15, 64'hFEDC_BA98_7654_3210, 3'b000, 6};
    vt[17] = '{1'b0, 3'd0, 64'h1000, 64'h0, 5'd16, 64'h0, 0, 1'b0,
               64'h1000, 8'h00, 64'h0, 5'd16, 64'h0, 3'b001, 18};
    vt[18] = '{1'b1, 3'd3, 64'h2000, 64'h5555_5555_5555_5555, 5'd9, 64'h0, 100, 1'b0,
               64'h2000, 8'hFF, 64'h5555_5555_5555_5555, 5'd0, 64'h0, 3'b001, 17};
    vt[19] = '{1'b1, 3'd5, 64'h2001, 64'h1234, 5'd4, 64'h0, 0, 1'b0,
               64'h0, 8'h00, 64'h0, 5'd0, 64'h0, 3'b100, 1};

    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_func3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0; req_rd = 5'd0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rdata = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst req_ready", req_ready, 1'b1);
    chk("rst mem_req_valid", mem_req_valid, 1'b0);
    chk("rst mem_addr", mem_addr, 64'd0);
    chk("rst mem_wstrb", mem_wstrb, 8'h00);
    chk("rst done_valid", done_valid, 1'b0);
    chk("rst done_data", done_data, 64'd0);
    chk("rst exc", {exc_illegal, exc_misaligned, exc_bus_err}, 3'b000);

    for (int i = 0; i < 20; i++) run_vec(i, vt[i]);

    // Reset while a load sits in WAIT: abort with no completion, late response ignored.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'd3;
    req_addr = 64'h3000; req_rd = 5'd20; mem_req_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstw mem_req_valid", mem_req_valid, 1'b1);
    @(negedge clk);
    chk("rstw in_wait", {req_ready, mem_req_valid, done_valid}, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw req_ready", req_ready, 1'b1);
    chk("rstw done_valid", done_valid, 1'b0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
        if (done_valid || !req_ready || mem_req_valid) seen++;
        @(negedge clk);
      end
      chk("rstw late_rsp_ignored", seen, 0);
    end

    run_vec(20, vt[0]);
    chk("sb drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
